// File: rtl/calc_entry.sv
// Keypad entry sequencer: synchronises key strobes, assembles {opcode, B, A}
// and hands the coded word to the ALU when EQ is accepted.
module calc_entry (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_strobe,
   input  logic [4:0]  key_code,
   output logic [11:0] nr_coded,
   output logic        coded_valid,
   output logic [3:0]  disp_val,
   output logic [2:0]  state,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      OPA  = 3'd1,
      OPW  = 3'd2,
      OPB  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t     st;
   logic       s1, s2, s3;
   logic       ev;
   logic [3:0] a, b, oper;
   logic [3:0] key_val;
   logic       is_digit, is_clr, is_eq, is_op;

   assign state    = st;
   assign ev       = s2 & ~s3;
   assign key_val  = key_code[3:0];
   assign is_digit = ~key_code[4];
   assign is_clr   = (key_code == 5'h10);
   assign is_eq    = (key_code == 5'h1F);
   assign is_op    = key_code[4] && (key_val >= 4'd1) && (key_val <= 4'd13);

   // Synchroniser presets to 1 so a strobe already high at reset release is
   // seen as "old" and produces no event.
   // NOTE: every flop here uses <= so all stages sample the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= key_strobe;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Single-process FSM; all outputs registered. Anything not listed as legal
   // for a state sends it to ERR, which only CLR leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= IDLE;
         a           <= '0;
         b           <= '0;
         oper        <= '0;
         nr_coded    <= '0;
         disp_val    <= '0;
         coded_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         coded_valid <= 1'b0;
         if (ev) begin
            if (is_clr) begin
               st       <= IDLE;
               a        <= '0;
               b        <= '0;
               oper     <= '0;
               nr_coded <= '0;
               disp_val <= '0;
               err      <= 1'b0;
            end else begin
               case (st)
                  IDLE: begin
                     if (is_digit) begin
                        a        <= key_val;
                        disp_val <= key_val;
                        st       <= OPA;
                     end else begin
                        st  <= ERR;
                        err <= 1'b1;
                     end
                  end
                  OPA: begin
                     if (is_digit) begin
                        a        <= key_val;
                        disp_val <= key_val;
                     end else if (is_op) begin
                        oper <= key_val;
                        st   <= OPW;
                     end else begin
                        st  <= ERR;
                        err <= 1'b1;
                     end
                  end
                  OPW: begin
                     if (is_digit) begin
                        b        <= key_val;
                        disp_val <= key_val;
                        st       <= OPB;
                     end else if (is_op) begin
                        oper <= key_val;
                     end else begin
                        st  <= ERR;
                        err <= 1'b1;
                     end
                  end
                  OPB: begin
                     if (is_digit) begin
                        b        <= key_val;
                        disp_val <= key_val;
                     end else if (is_eq) begin
                        nr_coded    <= {oper, b, a};
                        coded_valid <= 1'b1;
                        st          <= DONE;
                     end else begin
                        st  <= ERR;
                        err <= 1'b1;
                     end
                  end
                  DONE: begin
                     if (is_digit) begin
                        a        <= key_val;
                        b        <= '0;
                        oper     <= '0;
                        disp_val <= key_val;
                        st       <= OPA;
                     end else if (is_eq) begin
                        coded_valid <= 1'b1;
                     end else begin
                        st  <= ERR;
                        err <= 1'b1;
                     end
                  end
                  default: begin
                     st  <= ERR;
                     err <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_calc_entry.sv
// Self-checking bench for calc_entry: directed table, reset corner cases and
// random key sequences against a key-level reference model.
module tb_calc_entry;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_strobe;
   logic [4:0]  key_code;
   logic [11:0] nr_coded;
   logic        coded_valid;
   logic [3:0]  disp_val;
   logic [2:0]  state;
   logic        err;

   calc_entry dut (
      .clk         (clk),
      .rst         (rst),
      .key_strobe  (key_strobe),
      .key_code    (key_code),
      .nr_coded    (nr_coded),
      .coded_valid (coded_valid),
      .disp_val    (disp_val),
      .state       (state),
      .err         (err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: behaviour per key, expressed on whole keys.
   localparam int M_IDLE = 0, M_OPA = 1, M_OPW = 2, M_OPB = 3, M_DONE = 4, M_ERR = 5;
   int         m_st;
   int         m_a, m_b, m_op, m_nr, m_disp;
   int         m_pulses = 0;
   int         pulses_seen = 0;

   task automatic model_reset();
      m_st = M_IDLE; m_a = 0; m_b = 0; m_op = 0; m_nr = 0; m_disp = 0;
   endtask

   task automatic model_key(input logic [4:0] c);
      int v;
      v = int'(c[3:0]);
      if (c == 5'h10) begin
         model_reset();
      end else if (m_st == M_ERR) begin
      end else if (c[4] == 1'b0) begin
         m_disp = v;
         if (m_st == M_IDLE || m_st == M_OPA) begin m_a = v; m_st = M_OPA; end
         else if (m_st == M_OPW || m_st == M_OPB) begin m_b = v; m_st = M_OPB; end
         else begin m_a = v; m_b = 0; m_op = 0; m_st = M_OPA; end
      end else if (c == 5'h1F) begin
         if (m_st == M_OPB) begin
            m_nr = m_op * 256 + m_b * 16 + m_a;
            m_pulses++;
            m_st = M_DONE;
         end else if (m_st == M_DONE) m_pulses++;
         else m_st = M_ERR;
      end else if (c != 5'h1E && v >= 1 && v <= 13 && (m_st == M_OPA || m_st == M_OPW)) begin
         m_op = v;
         m_st = M_OPW;
      end else begin
         m_st = M_ERR;
      end
   endtask

   // Count valid pulses and confirm the word shown alongside each one.
   always @(negedge clk) begin
      if (coded_valid) begin
         pulses_seen++;
         check("nr_at_pulse", nr_coded, m_nr);
      end
   end

   task automatic press(input logic [4:0] c);
      model_key(c);
      @(negedge clk);
      key_code   = c;
      key_strobe = 1'b1;
      repeat (4) @(negedge clk);
      key_strobe = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_vs_model(input string tag);
      check({tag, "_state"},  state, m_st);
      check({tag, "_nr"},     nr_coded, m_nr);
      check({tag, "_disp"},   disp_val, m_disp);
      check({tag, "_err"},    err, (m_st == M_ERR));
      check({tag, "_pulses"}, pulses_seen, m_pulses);
   endtask

   typedef struct {
      logic [4:0]  code;
      logic [2:0]  st;
      logic [11:0] nr;
      logic [3:0]  disp;
      logic        err;
      int          pulses;
   } vec_t;

   vec_t vecs[20];

   initial begin
      vecs[0]  = '{5'h03, 3'd1, 12'h000, 4'd3, 1'b0, 0};
      vecs[1]  = '{5'h11, 3'd2, 12'h000, 4'd3, 1'b0, 0};
      vecs[2]  = '{5'h04, 3'd3, 12'h000, 4'd4, 1'b0, 0};
      vecs[3]  = '{5'h1F, 3'd4, 12'h143, 4'd4, 1'b0, 1};
      vecs[4]  = '{5'h1F, 3'd4, 12'h143, 4'd4, 1'b0, 2};
      vecs[5]  = '{5'h08, 3'd1, 12'h143, 4'd8, 1'b0, 2};
      vecs[6]  = '{5'h10, 3'd0, 12'h000, 4'd0, 1'b0, 2};
      vecs[7]  = '{5'h03, 3'd1, 12'h000, 4'd3, 1'b0, 2};
      vecs[8]  = '{5'h07, 3'd1, 12'h000, 4'd7, 1'b0, 2};
      vecs[9]  = '{5'h12, 3'd2, 12'h000, 4'd7, 1'b0, 2};
      vecs[10] = '{5'h11, 3'd2, 12'h000, 4'd7, 1'b0, 2};
      vecs[11] = '{5'h09, 3'd3, 12'h000, 4'd9, 1'b0, 2};
      vecs[12] = '{5'h02, 3'd3, 12'h000, 4'd2, 1'b0, 2};
      vecs[13] = '{5'h1F, 3'd4, 12'h127, 4'd2, 1'b0, 3};
      vecs[14] = '{5'h10, 3'd0, 12'h000, 4'd0, 1'b0, 3};
      vecs[15] = '{5'h1F, 3'd5, 12'h000, 4'd0, 1'b1, 3};
      vecs[16] = '{5'h06, 3'd5, 12'h000, 4'd0, 1'b1, 3};
      vecs[17] = '{5'h10, 3'd0, 12'h000, 4'd0, 1'b0, 3};
      vecs[18] = '{5'h1E, 3'd5, 12'h000, 4'd0, 1'b1, 3};
      vecs[19] = '{5'h10, 3'd0, 12'h000, 4'd0, 1'b0, 3};

      rst        = 1'b1;
      key_strobe = 1'b0;
      key_code   = 5'h00;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_state", state, 0);
      check("rst_nr",    nr_coded, 0);
      check("rst_valid", coded_valid, 0);
      check("rst_disp",  disp_val, 0);
      check("rst_err",   err, 0);

      for (int i = 0; i < 20; i++) begin
         press(vecs[i].code);
         check($sformatf("vec%0d_state", i),  state, vecs[i].st);
         check($sformatf("vec%0d_nr", i),     nr_coded, vecs[i].nr);
         check($sformatf("vec%0d_disp", i),   disp_val, vecs[i].disp);
         check($sformatf("vec%0d_err", i),    err, vecs[i].err);
         check($sformatf("vec%0d_pulses", i), pulses_seen, vecs[i].pulses);
      end

      // Strobe held high across reset release must not produce an event.
      @(negedge clk);
      key_code   = 5'h05;
      key_strobe = 1'b1;
      rst        = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      key_strobe = 1'b0;
      repeat (4) @(negedge clk);
      check("hold_rst_state", state, 0);
      check("hold_rst_disp",  disp_val, 0);
      press(5'h02);
      check("after_hold_state", state, 1);
      check("after_hold_disp",  disp_val, 2);

      // Asynchronous reset in OPB: outputs clear before any clock edge.
      press(5'h11);
      press(5'h04);
      check("pre_async_state", state, 3);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("async_state", state, 0);
      check("async_nr",    nr_coded, 0);
      check("async_valid", coded_valid, 0);
      check("async_disp",  disp_val, 0);
      check("async_err",   err, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_vs_model("post_async");

      // Random key sequences against the model.
      for (int n = 0; n < 300; n++) begin
         int r;
         logic [4:0] c;
         r = $urandom_range(0, 15);
         if (r == 0)      c = 5'h10;
         else if (r <= 2) c = 5'h1F;
         else if (r <= 5) c = {1'b1, 4'($urandom_range(1, 13))};
         else if (r == 6) c = ($urandom_range(0, 1) != 0) ? 5'h1E : {1'b0, 4'($urandom_range(0, 15))};
         else             c = {1'b0, 4'($urandom_range(0, 15))};
         press(c);
         check_vs_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
